// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, drives a req/ack instruction memory and loads
// the Fetch/Decode register around wait states, stalls and branch redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_KILL
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] tgt_q, tgt_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [3:0]  wait_q, wait_d;

    logic [31:0] pc_plus4;
    logic [3:0]  wait_inc;

    assign pc_plus4 = pc_q + 32'd4;
    assign wait_inc = (wait_q >= WAIT_LIMIT) ? wait_q : wait_q + 4'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        hold_d  = hold_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        wait_d  = wait_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                wait_d  = 4'd0;
            end
            S_REQ: begin
                if (PCSrcE) begin
                    wait_d = 4'd0;
                    if (imem_ack) begin
                        pc_d = PCTargetE;
                    end else begin
                        tgt_d   = PCTargetE;
                        state_d = S_KILL;
                    end
                end else if (imem_ack) begin
                    wait_d = 4'd0;
                    if (StallF) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pcd_d   = pc_q;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else begin
                    wait_d = wait_inc;
                    if (!StallF) begin
                        valid_d = 1'b0;
                    end
                end
            end
            S_KILL: begin
                // The wrong-path request must complete before the address may change.
                if (imem_ack) begin
                    wait_d  = 4'd0;
                    pc_d    = PCSrcE ? PCTargetE : tgt_q;
                    state_d = S_REQ;
                end else if (PCSrcE) begin
                    tgt_d  = PCTargetE;
                    wait_d = 4'd0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_HOLD: begin
                wait_d = 4'd0;
                if (PCSrcE) begin
                    pc_d    = PCTargetE;
                    hold_d  = 32'd0;
                    state_d = S_REQ;
                end else if (!StallF) begin
                    instr_d = hold_q;
                    pcd_d   = pc_q;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect squashes whatever Decode holds, even under a stall.
        if (PCSrcE) begin
            instr_d = 32'd0;
            pcd_d   = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end

        if (wait_d == WAIT_LIMIT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd0;
            hold_q  <= 32'd0;
            tgt_q   <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            hold_q  <= hold_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign imem_req  = (state_q == S_REQ) || (state_q == S_KILL);
    assign imem_addr = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;
    assign FetchErr  = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with constant
// expectations plus a randomized run against a queue-based behavioural model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchErr;

    logic        req2, ack2, valid2, err2;
    logic [31:0] addr2, rdata2, instr2, pcd2, p4d2;

    int total = 0;
    int bad   = 0;

    int          mem_wait   = 0;
    logic        mem_stuck  = 1'b0;
    logic [31:0] mem_xor    = 32'd0;
    logic        in_flight  = 1'b0;
    int          waits_left = 0;

    logic        m_started;
    logic [31:0] m_pc, m_instr, m_pcd, m_pcp4;
    logic        m_valid, m_err;
    int          m_wait;
    logic [31:0] m_kill[$];
    logic [31:0] m_hold[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallF(StallF),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchErr(FetchErr)
    );

    // Second copy starts just below the 32-bit wrap and sees an always-ready memory.
    fetch_sequencer #(.RESET_PC(32'hFFFFFFFC)) dut2 (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallF(StallF),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .InstrD(instr2), .PCD(pcd2), .PCPlus4D(p4d2), .ValidD(valid2), .FetchErr(err2)
    );

    assign ack2   = req2;
    assign rdata2 = addr2;

    task automatic model_deliver(input logic [31:0] w);
        m_instr = w;
        m_pcd   = m_pc;
        m_pcp4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    // Reference behaviour: a pending wrong-path target or a buffered word is
    // tracked as a one-entry queue; the request is live unless a word is buffered.
    task automatic model_step(input logic r, input logic ack, input logic [31:0] rd);
        if (r) begin
            m_started = 1'b0;
            m_pc      = 32'h0;
            m_instr   = 32'h0;
            m_pcd     = 32'h0;
            m_pcp4    = 32'h0;
            m_valid   = 1'b0;
            m_err     = 1'b0;
            m_wait    = 0;
            m_kill.delete();
            m_hold.delete();
            return;
        end
        if (!m_started) begin
            m_started = 1'b1;
            m_wait    = 0;
        end else if (m_hold.size() != 0) begin
            if (PCSrcE) begin
                m_pc = PCTargetE;
                m_hold.delete();
            end else if (!StallF) begin
                model_deliver(m_hold[0]);
                m_hold.delete();
            end
        end else begin
            if (ack) begin
                m_wait = 0;
                if (PCSrcE) m_pc = PCTargetE;
                else if (m_kill.size() != 0) m_pc = m_kill[0];
                else if (StallF) m_hold.push_back(rd);
                else model_deliver(rd);
                m_kill.delete();
            end else if (PCSrcE) begin
                m_wait = 0;
                m_kill.delete();
                m_kill.push_back(PCTargetE);
            end else begin
                if (m_wait < 15) m_wait++;
                if (m_kill.size() == 0 && !StallF) m_valid = 1'b0;
            end
        end
        if (PCSrcE) begin
            m_instr = 32'h0;
            m_pcd   = 32'h0;
            m_pcp4  = 32'h0;
            m_valid = 1'b0;
        end
        if (m_wait >= 15) m_err = 1'b1;
    endtask

    // Called just after a falling edge: answer the memory, advance the model,
    // then move to the next falling edge.
    task automatic step();
        if (rst) begin
            imem_ack  = 1'b0;
            in_flight = 1'b0;
        end else if (imem_req) begin
            if (!in_flight) begin
                in_flight  = 1'b1;
                waits_left = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
            end
            if (mem_stuck) begin
                imem_ack = 1'b0;
            end else if (waits_left > 0) begin
                imem_ack = 1'b0;
                waits_left--;
            end else begin
                imem_ack  = 1'b1;
                in_flight = 1'b0;
            end
        end else begin
            imem_ack = 1'b0;
        end
        imem_rdata = imem_ack ? (imem_addr ^ mem_xor) : $urandom();
        model_step(rst, imem_ack, imem_rdata);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        PCSrcE = 1'b0;
        StallF = 1'b0;
        rst    = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({InstrD, PCD, PCPlus4D, ValidD, FetchErr} !== {96'h0, 2'b00}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got instr=%h pcd=%h p4=%h v=%b e=%b want all zero",
                     InstrD, PCD, PCPlus4D, ValidD, FetchErr);
        end
        total++;
        if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL reset_req: got req=%b addr=%h want req=0 addr=00000000", imem_req, imem_addr);
        end
        total++;
        if ({req2, addr2} !== {1'b0, 32'hFFFFFFFC}) begin
            bad++;
            $display("[TB] FAIL reset_pc_param: got req=%b addr=%h want req=0 addr=fffffffc", req2, addr2);
        end
        rst = 1'b0;
        step();
        total++;
        if (imem_req !== 1'b1 || ValidD !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_to_req: got req=%b valid=%b want req=1 valid=0", imem_req, ValidD);
        end
    endtask

    task automatic test_zero_wait();
        mem_wait = 0;
        mem_xor  = 32'h0;
        do_reset();
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zw_idle_req: got %b want 0", imem_req);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = 32'(4 * i);
            step();
            total++;
            if ({ValidD, PCD, InstrD, PCPlus4D} !== {1'b1, e, e, e + 32'd4}) begin
                bad++;
                $display("[TB] FAIL zw_stream%0d: got v=%b pcd=%h instr=%h p4=%h want v=1 pcd=%h instr=%h p4=%h",
                         i, ValidD, PCD, InstrD, PCPlus4D, e, e, e + 32'd4);
            end
        end
    endtask

    task automatic test_wait3();
        mem_wait = 3;
        do_reset();
        step();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            a = 32'(4 * k);
            for (int w = 0; w < 4; w++) begin
                step();
                total++;
                if (w < 3) begin
                    if ({ValidD, imem_req, imem_addr} !== {1'b0, 1'b1, a}) begin
                        bad++;
                        $display("[TB] FAIL w3_wait k%0d w%0d: got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                                 k, w, ValidD, imem_req, imem_addr, a);
                    end
                end else begin
                    if ({ValidD, PCD, InstrD} !== {1'b1, a, a}) begin
                        bad++;
                        $display("[TB] FAIL w3_deliver k%0d: got v=%b pcd=%h instr=%h want v=1 pcd=%h instr=%h",
                                 k, ValidD, PCD, InstrD, a, a);
                    end
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        mem_wait = 0;
        do_reset();
        step();
        step();
        step();
        StallF = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({imem_req, ValidD, PCD, InstrD} !== {1'b0, 1'b1, 32'h4, 32'h4}) begin
                bad++;
                $display("[TB] FAIL hold_cycle%0d: got req=%b v=%b pcd=%h instr=%h want req=0 v=1 pcd=4 instr=4",
                         i, imem_req, ValidD, PCD, InstrD);
            end
        end
        StallF = 1'b0;
        step();
        total++;
        if ({ValidD, PCD, InstrD, imem_req, imem_addr} !== {1'b1, 32'h8, 32'h8, 1'b1, 32'hC}) begin
            bad++;
            $display("[TB] FAIL hold_release: got v=%b pcd=%h instr=%h req=%b addr=%h want v=1 pcd=8 instr=8 req=1 addr=c",
                     ValidD, PCD, InstrD, imem_req, imem_addr);
        end
        step();
        total++;
        if ({ValidD, PCD} !== {1'b1, 32'hC}) begin
            bad++;
            $display("[TB] FAIL hold_next: got v=%b pcd=%h want v=1 pcd=c", ValidD, PCD);
        end
    endtask

    task automatic test_redirect_kill();
        mem_wait = 0;
        do_reset();
        step();
        for (int i = 0; i < 8; i++) step();
        mem_wait  = 3;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        total++;
        if ({imem_req, imem_addr, ValidD, InstrD, PCD} !== {1'b1, 32'h20, 1'b0, 32'h0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL kill_enter: got req=%b addr=%h v=%b instr=%h pcd=%h want req=1 addr=20 v=0 instr=0 pcd=0",
                     imem_req, imem_addr, ValidD, InstrD, PCD);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ea;
            ea = (i < 2) ? 32'h20 : 32'h100;
            step();
            total++;
            if ({imem_addr, ValidD} !== {ea, 1'b0}) begin
                bad++;
                $display("[TB] FAIL kill_wait%0d: got addr=%h v=%b want addr=%h v=0", i, imem_addr, ValidD, ea);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (i < 3) begin
                if (ValidD !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL kill_target_wait%0d: got v=%b want v=0", i, ValidD);
                end
            end else if ({ValidD, PCD, InstrD} !== {1'b1, 32'h100, 32'h100}) begin
                bad++;
                $display("[TB] FAIL kill_target: got v=%b pcd=%h instr=%h want v=1 pcd=100 instr=100",
                         ValidD, PCD, InstrD);
            end
        end
    endtask

    task automatic test_hold_redirect();
        mem_wait = 0;
        do_reset();
        step();
        step();
        StallF = 1'b1;
        step();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h200;
        step();
        total++;
        if ({InstrD, ValidD, PCD, imem_req, imem_addr} !== {32'h0, 1'b0, 32'h0, 1'b1, 32'h200}) begin
            bad++;
            $display("[TB] FAIL hold_redirect: got instr=%h v=%b pcd=%h req=%b addr=%h want instr=0 v=0 pcd=0 req=1 addr=200",
                     InstrD, ValidD, PCD, imem_req, imem_addr);
        end
        PCSrcE = 1'b0;
        StallF = 1'b0;
        step();
        total++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h200, 32'h200}) begin
            bad++;
            $display("[TB] FAIL hold_redirect_fetch: got v=%b pcd=%h instr=%h want v=1 pcd=200 instr=200",
                     ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        total++;
        if ({req2, addr2} !== {1'b1, 32'hFFFFFFFC}) begin
            bad++;
            $display("[TB] FAIL wrap_first: got req=%b addr=%h want req=1 addr=fffffffc", req2, addr2);
        end
        step();
        total++;
        if ({valid2, pcd2, p4d2, addr2} !== {1'b1, 32'hFFFFFFFC, 32'h0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL wrap_second: got v=%b pcd=%h p4=%h addr=%h want v=1 pcd=fffffffc p4=0 addr=0",
                     valid2, pcd2, p4d2, addr2);
        end
        step();
        total++;
        if ({valid2, pcd2, instr2} !== {1'b1, 32'h0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL wrap_zero: got v=%b pcd=%h instr=%h want v=1 pcd=0 instr=0", valid2, pcd2, instr2);
        end
    endtask

    task automatic test_timeout();
        mem_wait  = 0;
        mem_stuck = 1'b1;
        do_reset();
        step();
        for (int i = 0; i < 14; i++) step();
        total++;
        if (FetchErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_early: got %b want 0 after 14 waits", FetchErr);
        end
        step();
        total++;
        if (FetchErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_set: got %b want 1 after 15 waits", FetchErr);
        end
        for (int i = 0; i < 3; i++) step();
        mem_stuck = 1'b0;
        step();
        total++;
        if ({FetchErr, ValidD, PCD} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("[TB] FAIL timeout_sticky: got err=%b v=%b pcd=%h want err=1 v=1 pcd=0", FetchErr, ValidD, PCD);
        end
        do_reset();
        total++;
        if (FetchErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_clear: got %b want 0 after reset", FetchErr);
        end
    endtask

    task automatic test_random();
        mem_wait = -1;
        mem_xor  = $urandom();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic m_req;
            rst       = ($urandom_range(0, 99) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            PCTargetE = $urandom();
            StallF    = ($urandom_range(0, 3) == 0);
            step();
            m_req = m_started && (m_hold.size() == 0);
            total++;
            if ({InstrD, PCD, PCPlus4D, ValidD, FetchErr, imem_req, imem_addr} !==
                {m_instr, m_pcd, m_pcp4, m_valid, m_err, m_req, m_pc}) begin
                bad++;
                $display("[TB] FAIL random_c%0d: got instr=%h pcd=%h p4=%h v=%b e=%b req=%b addr=%h want instr=%h pcd=%h p4=%h v=%b e=%b req=%b addr=%h",
                         c, InstrD, PCD, PCPlus4D, ValidD, FetchErr, imem_req, imem_addr,
                         m_instr, m_pcd, m_pcp4, m_valid, m_err, m_req, m_pc);
            end
        end
        rst    = 1'b0;
        PCSrcE = 1'b0;
        StallF = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        PCSrcE     = 1'b0;
        PCTargetE  = 32'h0;
        StallF     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_wait3();
        test_stall_hold();
        test_redirect_kill();
        test_hold_redirect();
        test_wrap();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
